// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one 64/32 sequential divider among NREQ requesters.
// Requesters are granted round-robin; the divider's sync reset doubles as its
// start strobe, and the result goes back through a valid/ready response port.
// Optional build macro: DIV_ZERO_CHECK_EN - answer a zero divisor directly
// (quot all ones, rem = dividend, err = 1) without starting the divider.
module div_share_ctrl #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int TMO_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*64-1:0]   req_dvdend,
    input  logic [NREQ*32-1:0]   req_dvsor,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_quot,
    output logic [63:0]          rsp_rem,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 div_reset,
    output logic [63:0]          div_dvdend,
    output logic [31:0]          div_dvsor,
    input  logic [31:0]          div_quot,
    input  logic [63:0]          div_rem,
    input  logic                 div_fin
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RESP} state_t;

    localparam int            CW       = $clog2(TMO_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_id;
    logic [63:0]     sel_dvdend;
    logic [31:0]     sel_dvsor;
    logic            accept;
    logic            timeout;
    logic            zero_skip;
    logic            div_reset_nxt;

    // One-hot of the first valid requester after ptr, wrapping around.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                                input logic [IDW-1:0]  ptr);
        logic [NREQ-1:0] g;
        int              idx;
        g = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if ((g == '0) && vld[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

    // Binary index of a one-hot vector.
    function automatic logic [IDW-1:0] oh_index(input logic [NREQ-1:0] oh);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (oh[k]) idx = IDW'(k);
        end
        return idx;
    endfunction

    // Arbitration: pick the round-robin winner and route its operands.
    always_comb begin
        grant      = rr_pick(req_valid, rr_ptr);
        win_id     = oh_index(grant);
        sel_dvdend = '0;
        sel_dvsor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_dvdend = req_dvdend[64*i +: 64];
                sel_dvsor  = req_dvsor[32*i +: 32];
            end
        end
    end

    assign accept  = (state == S_IDLE) && (grant != '0);
    assign timeout = (cnt == CNT_LAST);

`ifdef DIV_ZERO_CHECK_EN
    assign zero_skip = (sel_dvsor == 32'd0);
`else
    assign zero_skip = 1'b0;
`endif

    // Next-state logic; req_ready is the only combinational output.
    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        div_reset_nxt = div_reset;
        case (state)
            S_IDLE: begin
                req_ready     = grant;
                div_reset_nxt = 1'b1;
                if (accept) state_nxt = zero_skip ? S_RESP : S_START;
            end
            S_START: begin
                // Divider saw reset with stable operands; release it now.
                state_nxt     = S_RUN;
                div_reset_nxt = 1'b0;
            end
            S_RUN: begin
                if (div_fin || timeout) state_nxt = S_RESP;
            end
            S_RESP: begin
                // Divider stays out of reset (fin sticky) until the consumer takes the result.
                if (rsp_ready) begin
                    state_nxt     = S_IDLE;
                    div_reset_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control registers: state and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            div_reset <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_reset <= div_reset_nxt;
            rsp_valid <= (state_nxt == S_RESP);
            busy      <= (state_nxt != S_IDLE);
        end
    end

    // Operand latch, timeout counter and response capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= IDW'(NREQ - 1);
            cnt        <= '0;
            rsp_id     <= '0;
            rsp_quot   <= '0;
            rsp_rem    <= '0;
            rsp_err    <= 1'b0;
            div_dvdend <= '0;
            div_dvsor  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_dvdend <= sel_dvdend;
                        div_dvsor  <= sel_dvsor;
                        rsp_id     <= win_id;
                        rr_ptr     <= win_id;
                        if (zero_skip) begin
                            rsp_quot <= '1;
                            rsp_rem  <= sel_dvdend;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                S_START: cnt <= '0;
                S_RUN: begin
                    if (div_fin) begin
                        rsp_quot <= div_quot;
                        rsp_rem  <= div_rem;
                        rsp_err  <= 1'b0;
                    end else if (timeout) begin
                        rsp_quot <= '0;
                        rsp_rem  <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
